// File: rtl/repair_rx.sv
// Responder half of the MBTRAIN.REPAIR sideband handshake: answers INIT / APPLY_DEGRADE / END
// requests, latches the partner lane encoding, reports completion. Optional REPAIR_RX_TIMEOUT_EN.
module repair_rx #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_sideband_message,
  input  logic       i_sideband_valid,
  input  logic [2:0] i_sideband_data_lanes_encoding,
  input  logic       i_busy_negedge_detected,
  input  logic       i_valid_tx,
  output logic [3:0] o_sideband_message,
  output logic       o_valid_rx,
  output logic [2:0] o_functional_lanes,
  output logic       o_degrade_fail,
  output logic       o_test_ack,
  output logic       o_timeout
);

  localparam logic [3:0] MSG_NONE     = 4'b0000;
  localparam logic [3:0] MSG_INIT_REQ = 4'b0001;
  localparam logic [3:0] MSG_INIT_RSP = 4'b0010;
  localparam logic [3:0] MSG_END_REQ  = 4'b0101;
  localparam logic [3:0] MSG_END_RSP  = 4'b0110;
  localparam logic [3:0] MSG_DEG_REQ  = 4'b0111;
  localparam logic [3:0] MSG_DEG_RSP  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WAIT_DEG  = 3'd2,
    ST_WAIT_END  = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  function automatic logic enc_unusable(input logic [2:0] enc);
    logic bad;
    case (enc)
      3'b011, 3'b001, 3'b010: bad = 1'b0;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] msg_q, msg_d;
  logic       valid_q, valid_d;
  logic [2:0] lanes_q, lanes_d;
  logic       fail_q, fail_d;
  logic       ack_q, ack_d;
  logic       timeout_q, timeout_d;
  logic       load_s;
  logic       timeout_hit_s;

  logic acc_init_s, acc_deg_s, acc_end_s, in_wait_s;
  assign acc_init_s = i_sideband_valid && (i_sideband_message == MSG_INIT_REQ);
  assign acc_deg_s  = i_sideband_valid && (i_sideband_message == MSG_DEG_REQ);
  assign acc_end_s  = i_sideband_valid && (i_sideband_message == MSG_END_REQ);
  assign in_wait_s  = (state_q == ST_WAIT_INIT) || (state_q == ST_WAIT_DEG) ||
                      (state_q == ST_WAIT_END);

`ifdef REPAIR_RX_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_wait_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit_s = in_wait_s && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout     = timeout_q;
`else
  assign timeout_hit_s = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_INIT;
        ST_WAIT_INIT: begin
          if (timeout_hit_s)   state_d = ST_FINISH;
          else if (acc_init_s) state_d = ST_WAIT_DEG;
          else                 state_d = ST_WAIT_INIT;
        end
        ST_WAIT_DEG: begin
          if (timeout_hit_s)  state_d = ST_FINISH;
          else if (acc_deg_s) state_d = ST_WAIT_END;
          else                state_d = ST_WAIT_DEG;
        end
        ST_WAIT_END: begin
          if (timeout_hit_s)  state_d = ST_FINISH;
          else if (acc_end_s) state_d = ST_FINISH;
          else                state_d = ST_WAIT_END;
        end
        ST_FINISH: state_d = ST_FINISH;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Each wait state also answers a retransmit of the request that got us into it.
  always_comb begin
    msg_d     = msg_q;
    valid_d   = valid_q;
    lanes_d   = lanes_q;
    fail_d    = fail_q;
    ack_d     = ack_q;
    timeout_d = timeout_q;
    load_s    = 1'b0;
    if (!i_en || (state_q == ST_IDLE)) begin
      msg_d     = MSG_NONE;
      valid_d   = 1'b0;
      lanes_d   = 3'b000;
      fail_d    = 1'b0;
      ack_d     = 1'b0;
      timeout_d = 1'b0;
    end else if (timeout_hit_s) begin
      valid_d   = 1'b0;
      timeout_d = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_INIT: begin
          if (acc_init_s) begin
            msg_d  = MSG_INIT_RSP;
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        ST_WAIT_DEG: begin
          if (acc_deg_s) begin
            msg_d   = MSG_DEG_RSP;
            lanes_d = i_sideband_data_lanes_encoding;
            fail_d  = enc_unusable(i_sideband_data_lanes_encoding);
            load_s  = 1'b1;
          end else if (acc_init_s) begin
            msg_d  = MSG_INIT_RSP;
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        ST_WAIT_END: begin
          if (acc_end_s) begin
            msg_d  = MSG_END_RSP;
            load_s = 1'b1;
          end else if (acc_deg_s) begin
            msg_d   = MSG_DEG_RSP;
            lanes_d = i_sideband_data_lanes_encoding;
            fail_d  = enc_unusable(i_sideband_data_lanes_encoding);
            load_s  = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        ST_FINISH: begin
          if (acc_end_s && !ack_q && !timeout_q) begin
            msg_d  = MSG_END_RSP;
            load_s = 1'b1;
          end else if (!valid_q && !timeout_q) begin
            ack_d = 1'b1;
            msg_d = MSG_NONE;
          end else begin
            load_s = 1'b0;
          end
        end
        default: load_s = 1'b0;
      endcase
      if (load_s) begin
        valid_d = 1'b1;
      end else if (i_busy_negedge_detected && !i_valid_tx) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_q     <= MSG_NONE;
      valid_q   <= 1'b0;
      lanes_q   <= 3'b000;
      fail_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      msg_q     <= msg_d;
      valid_q   <= valid_d;
      lanes_q   <= lanes_d;
      fail_q    <= fail_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_sideband_message = msg_q;
  assign o_valid_rx         = valid_q;
  assign o_functional_lanes = lanes_q;
  assign o_degrade_fail     = fail_q;
  assign o_test_ack         = ack_q;

endmodule
